mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM). It accepts one request at a time, sequences it into 1, 2 or 4 byte accesses, and assembles or scatters little-endian words. It returns a one-cycle done pulse to the owning requester. It sits between the IF/MEM stages and the RAM, and takes over the byte-sequencing role from the requesters.

Parameters:
RAM_AW, 17, width of ram_addr_o; the internal address is 32 bits, truncated to the low RAM_AW bits at the port.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_req_i  in  1  IF read request; held until if_done_o or flush
if_addr_i  in  32  IF word address
if_flush_i  in  1  branch redirect; abort the in-flight IF read
if_done_o  out  1  one-cycle pulse; if_data_o valid
if_data_o  out  32  fetched instruction
mem_req_i  in  1  MEM request; held until mem_done_o
mem_we_i  in  1  1 = store, 0 = load
mem_size_i  in  2  0 = byte, 1 = half, 2 or 3 = word
mem_addr_i  in  32  byte address
mem_wdata_i  in  32  store data; byte k is bits [8k+7:8k]
mem_done_o  out  1  one-cycle pulse; load data valid and store complete
mem_rdata_o  out  32  load data, zero-extended (MEM sign-extends)
ram_addr_o  out  RAM_AW  RAM byte address
ram_wr_o  out  1  RAM write enable
ram_dout_o  out  8  RAM write byte
ram_din_i  in  8  RAM read byte; valid one cycle after the address is presented
busy_o  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset: state IDLE, cnt 0; every output 0 at the next edge, including ram_wr_o. Reset aborts any transaction in flight, with no done pulse.
- States: IDLE, IF_RD, MEM_RD, MEM_WR. Byte counter cnt[2:0]; length N is 4 for IF, otherwise from mem_size_i.
- Accept (IDLE only):
  - Requests are ignored at any edge where if_done_o or mem_done_o is high, giving a 1-cycle turnaround so a held req is not re-accepted.
  - Otherwise mem_req_i beats if_req_i (fixed priority).
  - IF is not accepted if if_flush_i is high at the same edge.
  - At acceptance edge E0: latch address, size, write data and we; go to IF_RD, MEM_RD or MEM_WR.
- Read sequencing (IF_RD / MEM_RD):
  - After edge Ek, ram_addr_o = addr+k, for k = 0..N-1.
  - Byte k is captured from ram_din_i at edge E(k+2) into bits [8k+7:8k].
  - After edge E(N+1): done pulse high for one cycle, data output valid, state IDLE.
  - Read latency from acceptance: IF 5 cycles; MEM byte 2, half 3, word 5.
  - Unread upper bytes of mem_rdata_o are 0.
- Write sequencing (MEM_WR):
  - After Ek: ram_wr_o = 1, ram_addr_o = addr+k, ram_dout_o = byte k, for k = 0..N-1.
  - After EN: ram_wr_o = 0, mem_done_o pulse, state IDLE.
- Address arithmetic: addr+k is modulo 2^32, then truncated to RAM_AW bits; no alignment check.
- ram_wr_o is 0 in every state other than MEM_WR.
- Flush:
  - if_flush_i high at any edge during IF_RD: abort to IDLE at that edge, no if_done_o, partial data discarded.
  - A flush at the acceptance edge blocks acceptance.
  - A flush has no effect on MEM_RD/MEM_WR, or on a done pulse already asserted.
  - A new IF request after the flush is accepted no earlier than the next IDLE edge.
- Stores are never aborted except by rst.
- if_data_o and mem_rdata_o hold their value between done pulses.
- busy_o is high from the cycle after E0 through the done cycle exclusive (IDLE in the done cycle).

Test Plan:
- Reset mid-store: rst asserted during MEM_WR byte 1 of a word store -> ram_wr_o=0 next cycle, no mem_done_o, busy_o=0.
- IF fetch: if_addr_i=0x100, RAM[0x100..0x103]=13,05,A0,00 -> if_done_o 5 cycles after accept, if_data_o=0x00A00513; ram_addr_o steps 0x100..0x103.
- Both requests in the same cycle: mem load byte at 0x204 (=0x9C) and IF at 0x0 -> mem_done_o after 2 cycles with mem_rdata_o=0x0000009C; IF accepted 1 cycle after the done pulse; if_done_o follows 5 cycles later.
- Half store: mem_we_i=1, size=1, addr=0x1FFFF, wdata=0xDEADBEEF -> ram_wr_o high 2 cycles writing EF@0x1FFFF then BE@0x00000 (wrap); mem_done_o next cycle.
- Flush: flush asserted 3 cycles into an IF read of 0x40 -> no if_done_o, IDLE next edge; new IF at 0x80 returns RAM[0x80] word.
- Held req: MEM holds mem_req_i one cycle past mem_done_o -> exactly one transaction performed.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF, MEM and RAM-side signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
    parameter int RAM_AW = 17
) ();
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_flush_i;
    logic              if_done_o;
    logic [31:0]       if_data_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_size_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_done_o;
    logic [31:0]       mem_rdata_o;
    logic [RAM_AW-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_done_o, if_data_o,
        input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o,
        output ram_addr_o, ram_wr_o, ram_dout_o,
        input  ram_din_i,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_done_o, if_data_o,
        output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o,
        input  ram_addr_o, ram_wr_o, ram_dout_o,
        output ram_din_i,
        input  busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and load/store,
// sequencing each request into little-endian byte accesses.
module mem_arbiter #(
    parameter int RAM_AW = 17
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [2:0]  len_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] acc_r;

    logic [2:0]  step_s;
    logic [31:0] merged_s;

    function automatic logic [2:0] size_len(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] k,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{k, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

    // cnt_r counts edges since acceptance minus one; the byte landing now is index cnt_r-1
    always_comb begin
        step_s   = cnt_r + 3'd1;
        merged_s = merge_byte(acc_r, cnt_r[1:0] - 2'd1, bus.ram_din_i);
    end

    // Arbitration, byte sequencing and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            cnt_r           <= 3'd0;
            len_r           <= 3'd0;
            addr_r          <= 32'd0;
            wdata_r         <= 32'd0;
            acc_r           <= 32'd0;
            bus.if_done_o   <= 1'b0;
            bus.if_data_o   <= 32'd0;
            bus.mem_done_o  <= 1'b0;
            bus.mem_rdata_o <= 32'd0;
            bus.ram_addr_o  <= {RAM_AW{1'b0}};
            bus.ram_wr_o    <= 1'b0;
            bus.ram_dout_o  <= 8'd0;
            bus.busy_o      <= 1'b0;
        end else begin
            bus.if_done_o  <= 1'b0;
            bus.mem_done_o <= 1'b0;
            bus.ram_wr_o   <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= 3'd0;
                    acc_r <= 32'd0;
                    // A done pulse on the outputs means the requester may still hold req
                    if (bus.if_done_o || bus.mem_done_o) begin
                        bus.busy_o <= 1'b0;
                    end else if (bus.mem_req_i) begin
                        len_r          <= size_len(bus.mem_size_i);
                        addr_r         <= bus.mem_addr_i;
                        wdata_r        <= bus.mem_wdata_i;
                        bus.ram_addr_o <= RAM_AW'(bus.mem_addr_i);
                        bus.busy_o     <= 1'b1;
                        if (bus.mem_we_i) begin
                            state_r        <= MEM_WR;
                            bus.ram_wr_o   <= 1'b1;
                            bus.ram_dout_o <= bus.mem_wdata_i[7:0];
                        end else begin
                            state_r <= MEM_RD;
                        end
                    end else if (bus.if_req_i && !bus.if_flush_i) begin
                        state_r        <= IF_RD;
                        len_r          <= 3'd4;
                        addr_r         <= bus.if_addr_i;
                        bus.ram_addr_o <= RAM_AW'(bus.if_addr_i);
                        bus.busy_o     <= 1'b1;
                    end else begin
                        bus.busy_o <= 1'b0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state_r == IF_RD && bus.if_flush_i) begin
                        state_r    <= IDLE;
                        cnt_r      <= 3'd0;
                        bus.busy_o <= 1'b0;
                    end else if (cnt_r == len_r) begin
                        state_r    <= IDLE;
                        cnt_r      <= 3'd0;
                        bus.busy_o <= 1'b0;
                        if (state_r == IF_RD) begin
                            bus.if_done_o <= 1'b1;
                            bus.if_data_o <= merged_s;
                        end else begin
                            bus.mem_done_o  <= 1'b1;
                            bus.mem_rdata_o <= merged_s;
                        end
                    end else begin
                        cnt_r <= step_s;
                        if (step_s < len_r) begin
                            bus.ram_addr_o <= RAM_AW'(addr_r + {29'd0, step_s});
                        end else begin
                            bus.ram_addr_o <= bus.ram_addr_o;
                        end
                        if (cnt_r != 3'd0) begin
                            acc_r <= merged_s;
                        end else begin
                            acc_r <= acc_r;
                        end
                    end
                end
                MEM_WR: begin
                    if (step_s < len_r) begin
                        cnt_r          <= step_s;
                        bus.ram_wr_o   <= 1'b1;
                        bus.ram_addr_o <= RAM_AW'(addr_r + {29'd0, step_s});
                        bus.ram_dout_o <= get_byte(wdata_r, step_s[1:0]);
                    end else begin
                        state_r        <= IDLE;
                        cnt_r          <= 3'd0;
                        bus.mem_done_o <= 1'b1;
                        bus.busy_o     <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= 3'd0;
                    bus.busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
